// File: rtl/siso_sched_pkg.sv
// siso_sched_pkg
//   Shared types and constant functions for the SISO shift scheduler.
//   - state_e     : scheduler FSM state encoding (IDLE, SHIFT)
//   - frame_len   : bits per serial frame for a given data width
//   - cnt_width   : width of the in-frame bit counter
//   - src_width   : width of a requester index (minimum 1 bit)
//   Configuration macro: SISO_SCHED_PARITY_EN appends an even-parity bit to
//   every frame, which makes a frame one bit longer than the data word.
package siso_sched_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic int frame_len(input int size);
`ifdef SISO_SCHED_PARITY_EN
    return size + 1;
`else
    return size;
`endif
  endfunction

  function automatic int cnt_width(input int size);
    int fl;
    fl = frame_len(size);
    return (fl <= 1) ? 1 : $clog2(fl);
  endfunction

  function automatic int src_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/siso_shift_scheduler_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. Searches req_i starting at index ptr_i
//   and wrapping modulo N; the first asserted request wins.
//   Ports:
//     req_i      in  N   request vector
//     ptr_i      in  W   highest-priority index for this evaluation
//     gnt_o      out N   one-hot grant (all zero when no request)
//     gnt_idx_o  out W   binary index of the granted requester
//     any_o      out 1   at least one request present
module rr_arbiter
  import siso_sched_pkg::*;
#(
  parameter int N = 2,
  parameter int W = src_width(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] gnt_idx_o,
  output logic         any_o
);

  // Rotating priority search: first requester at or after ptr_i, wrapping.
  always_comb begin : arb_search
    logic         found;
    logic [W-1:0] idx;
    int           j;
    found     = 1'b0;
    idx       = '0;
    j         = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int k = 0; k < N; k++) begin
      j   = (int'(ptr_i) + k) % N;
      idx = W'(j);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end else begin
        found = found;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/siso_shift_scheduler.sv
// siso_shift_scheduler
//   Shares one SIZE-bit serial shift chain between NUM_REQ parallel-word
//   requesters. A round-robin grant loads the chosen word, which is then
//   shifted out LSB first with valid/ready handshaking, first/last strobes
//   and the source index of the frame. Back-to-back frames run without a
//   bubble when a new request is waiting at the last-bit handshake.
//   Configuration macro: SISO_SCHED_PARITY_EN (adds an even-parity bit as
//   the final bit of each frame).
//   Ports:
//     clk        in   1              clock (posedge)
//     rst        in   1              synchronous active-high reset
//     req_valid  in   NUM_REQ        requester i holds a word
//     req_data   in   NUM_REQ x SIZE word of each requester
//     req_ready  out  NUM_REQ        one-hot accept strobe (or zero)
//     ser_out    out  1              serial bit
//     ser_valid  out  1              ser_out valid
//     ser_ready  in   1              consumer takes the bit
//     ser_first  out  1              first bit of frame
//     ser_last   out  1              last bit of frame
//     ser_src    out  SRC_W          source index of current frame
//     busy       out  1              frame in progress
module siso_shift_scheduler
  import siso_sched_pkg::*;
#(
  parameter int SIZE    = 4,
  parameter int NUM_REQ = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [SIZE-1:0]               req_data [NUM_REQ],
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          ser_out,
  output logic                          ser_valid,
  input  logic                          ser_ready,
  output logic                          ser_first,
  output logic                          ser_last,
  output logic [src_width(NUM_REQ)-1:0] ser_src,
  output logic                          busy
);

  localparam int FRAME_LEN = frame_len(SIZE);
  localparam int CNT_W     = cnt_width(SIZE);
  localparam int SRC_W     = src_width(NUM_REQ);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_REQ - 1);

  localparam logic [0:0] S_IDLE  = 1'(ST_IDLE);
  localparam logic [0:0] S_SHIFT = 1'(ST_SHIFT);

  logic [0:0]       state_q, state_d;
  logic [SIZE-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [SRC_W-1:0] rr_q,    rr_d;
  logic [SRC_W-1:0] src_q,   src_d;
`ifdef SISO_SCHED_PARITY_EN
  logic             par_q,   par_d;
`endif

  logic [NUM_REQ-1:0] gnt_s;
  logic [SRC_W-1:0]   gnt_idx_s;
  logic               any_s;
  logic               in_shift_s;
  logic               last_hs_s;
  logic               grant_win_s;
  logic               accept_s;
  logic [SRC_W-1:0]   next_ptr_s;

`ifdef SISO_SCHED_PARITY_EN
  function automatic logic even_parity(input logic [SIZE-1:0] d);
    return ^d;
  endfunction
`endif

  rr_arbiter #(
    .N (NUM_REQ),
    .W (SRC_W)
  ) u_arb (
    .req_i     (req_valid),
    .ptr_i     (rr_q),
    .gnt_o     (gnt_s),
    .gnt_idx_o (gnt_idx_s),
    .any_o     (any_s)
  );

  // Grant window: idle, or the cycle the last bit of a frame is handed off.
  always_comb begin
    in_shift_s  = (state_q == S_SHIFT);
    last_hs_s   = in_shift_s && ser_ready && (cnt_q == LAST_CNT);
    grant_win_s = (state_q == S_IDLE) || last_hs_s;
    accept_s    = grant_win_s && any_s;
  end

  // Round-robin pointer moves to the requester after the one just granted.
  always_comb begin
    if (gnt_idx_s == LAST_SRC) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = gnt_idx_s + SRC_W'(1'b1);
    end
  end

  // FSM next state, shift register, bit counter and pointer updates.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    src_d   = src_q;
`ifdef SISO_SCHED_PARITY_EN
    par_d   = par_q;
`endif
    if (accept_s) begin
      // Load covers both the idle grant and the zero-bubble frame chaining.
      state_d = S_SHIFT;
      shreg_d = req_data[gnt_idx_s];
      cnt_d   = '0;
      rr_d    = next_ptr_s;
      src_d   = gnt_idx_s;
`ifdef SISO_SCHED_PARITY_EN
      par_d   = even_parity(req_data[gnt_idx_s]);
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_SHIFT: begin
          if (ser_ready) begin
            if (cnt_q == LAST_CNT) begin
              state_d = S_IDLE;
              shreg_d = '0;
              cnt_d   = '0;
            end else begin
              shreg_d = shreg_q >> 1;
              cnt_d   = cnt_q + CNT_W'(1'b1);
            end
          end else begin
            state_d = S_SHIFT;
          end
        end
        default: begin
          state_d = S_IDLE;
          shreg_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      rr_q    <= '0;
      src_q   <= '0;
`ifdef SISO_SCHED_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      src_q   <= src_d;
`ifdef SISO_SCHED_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Output decode; every serial output reads zero outside a frame.
  always_comb begin
    req_ready = grant_win_s ? gnt_s : '0;
    ser_valid = in_shift_s;
    busy      = in_shift_s;
    ser_first = in_shift_s && (cnt_q == '0);
    ser_last  = in_shift_s && (cnt_q == LAST_CNT);
    ser_src   = in_shift_s ? src_q : '0;
    if (!in_shift_s) begin
      ser_out = 1'b0;
`ifdef SISO_SCHED_PARITY_EN
    end else if (cnt_q == LAST_CNT) begin
      // Parity occupies the slot after the SIZE data bits.
      ser_out = par_q;
`endif
    end else begin
      ser_out = shreg_q[0];
    end
  end

endmodule

// File: tb/tb_siso_shift_scheduler.sv
// tb_siso_shift_scheduler
//   Bench for siso_shift_scheduler (SIZE=4, NUM_REQ=2). Honours
//   SISO_SCHED_PARITY_EN when defined for the whole build.
module tb_siso_shift_scheduler;

  localparam int SIZE = 4;
  localparam int NREQ = 2;
`ifdef SISO_SCHED_PARITY_EN
  localparam int FL = SIZE + 1;
`else
  localparam int FL = SIZE;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NREQ-1:0]  req_valid = '0;
  logic [SIZE-1:0]  req_data [NREQ];
  logic [NREQ-1:0]  req_ready;
  logic             ser_out, ser_valid, ser_first, ser_last, busy;
  logic             ser_ready = 1'b1;
  logic [0:0]       ser_src;

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is a list of bits plus a read position.
  bit m_in  = 1'b0;
  int m_pos = 0;
  int m_src = 0;
  int m_rr  = 0;
  bit m_bits [FL];

  // Samples taken at the most recent compare point.
  logic            s_out, s_valid, s_first, s_last, s_busy;
  logic [0:0]      s_src;
  logic [NREQ-1:0] s_rdy;

  int sw_seq [5] = '{1, 1, 0, 1, 1};

  siso_shift_scheduler #(.SIZE(SIZE), .NUM_REQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_first (ser_first),
    .ser_last  (ser_last),
    .ser_src   (ser_src),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare at negedge against the model, advance model, cross posedge.
  task automatic step(input bit do_chk);
    int g;
    bit win;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (g < 0 && req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
    end
    win = !m_in || (ser_ready && m_pos == FL - 1);
    exp_rdy = '0;
    if (win && g >= 0) exp_rdy[g] = 1'b1;
    s_out = ser_out; s_valid = ser_valid; s_first = ser_first; s_last = ser_last;
    s_busy = busy; s_src = ser_src; s_rdy = req_ready;
    if (do_chk) begin
      chk("ser_valid", 32'(ser_valid), 32'(m_in));
      chk("busy", 32'(busy), 32'(m_in));
      chk("ser_out", 32'(ser_out), m_in ? 32'(m_bits[m_pos]) : 32'd0);
      chk("ser_first", 32'(ser_first), 32'(m_in && m_pos == 0));
      chk("ser_last", 32'(ser_last), 32'(m_in && m_pos == FL - 1));
      chk("ser_src", 32'(ser_src), m_in ? 32'(m_src) : 32'd0);
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    end
    if (rst) begin
      m_in = 1'b0; m_pos = 0; m_src = 0; m_rr = 0;
    end else if (m_in && !ser_ready) begin
      m_in = m_in;
    end else if (m_in && m_pos != FL - 1) begin
      m_pos++;
    end else if (g >= 0) begin
      m_in = 1'b1; m_pos = 0; m_src = g; m_rr = (g + 1) % NREQ;
      for (int b = 0; b < SIZE; b++) m_bits[b] = req_data[g][b];
      if (FL > SIZE) m_bits[FL-1] = ^req_data[g];
    end else begin
      m_in = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    step(1'b1);
    step(1'b1);
    rst = 1'b0;
  endtask

  initial begin
    int pulses;
    bit saw1;
    logic [4:0] w;
    req_data[0] = 4'h0;
    req_data[1] = 4'h0;
    step(1'b0);
    do_reset();

    // Reset state
    step(1'b1);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_out", 32'(s_out), 32'd0);
    chk("rst_first_last", 32'({s_first, s_last}), 32'd0);
    chk("rst_busy_src", 32'({s_busy, s_src}), 32'd0);

    // Single word 1011 from requester 0
    req_valid = 2'b01; req_data[0] = 4'b1011; ser_ready = 1'b1;
    step(1'b1);
    chk("sw_accept", 32'(s_rdy), 32'h1);
    req_valid = 2'b00;
    for (int k = 0; k < FL; k++) begin
      step(1'b1);
      chk("sw_bit", 32'(s_out), 32'(sw_seq[k]));
      chk("sw_first", 32'(s_first), 32'(k == 0));
      chk("sw_last", 32'(s_last), 32'(k == FL - 1));
      chk("sw_src", 32'(s_src), 32'd0);
    end
    step(1'b1);
    chk("sw_idle", 32'(s_valid), 32'd0);

    // Contention: alternate sources with no bubble
    do_reset();
    req_valid = 2'b11; req_data[0] = 4'hA; req_data[1] = 4'h5;
    step(1'b1);
    chk("ct_first_grant", 32'(s_rdy), 32'h1);
    pulses = 0;
    for (int f = 0; f < 4; f++) begin
      w = (f % 2 == 0) ? 5'b01010 : 5'b00101;
      for (int k = 0; k < FL; k++) begin
        step(1'b1);
        chk("ct_valid", 32'(s_valid), 32'd1);
        chk("ct_src", 32'(s_src), 32'(f % 2));
        chk("ct_bit", 32'(s_out), 32'(w[k]));
        if (s_rdy != '0) pulses++;
      end
    end
    chk("ct_ready_pulses", 32'(pulses), 32'd4);
    req_valid = 2'b00;

    // Backpressure mid-frame
    do_reset();
    req_valid = 2'b01; req_data[0] = 4'b1011;
    step(1'b1);
    req_valid = 2'b00;
    step(1'b1);
    ser_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1);
      chk("bp_hold_bit", 32'(s_out), 32'(sw_seq[1]));
      chk("bp_hold_first", 32'(s_first), 32'd0);
    end
    ser_ready = 1'b1;
    for (int k = 1; k < FL; k++) begin
      step(1'b1);
      chk("bp_bit", 32'(s_out), 32'(sw_seq[k]));
    end
    step(1'b1);
    chk("bp_idle", 32'(s_valid), 32'd0);

    // Reset mid-frame, rr pointer back to 0
    do_reset();
    req_valid = 2'b01;
    step(1'b1);
    req_valid = 2'b00;
    step(1'b1);
    step(1'b1);
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    req_valid = 2'b11;
    step(1'b1);
    chk("mr_valid", 32'(s_valid), 32'd0);
    chk("mr_out", 32'(s_out), 32'd0);
    chk("mr_grant", 32'(s_rdy), 32'h1);
    req_valid = 2'b00;
    step(1'b1);
    chk("mr_src", 32'(s_src), 32'd0);
    chk("mr_first", 32'(s_first), 32'd1);
    for (int k = 1; k < FL; k++) step(1'b1);

    // Withdrawn request while busy
    do_reset();
    req_valid = 2'b01;
    step(1'b1);
    req_valid = 2'b00;
    step(1'b1);
    req_valid = 2'b10;
    step(1'b1);
    chk("wd_no_ready", 32'(s_rdy), 32'd0);
    req_valid = 2'b00;
    saw1 = 1'b0;
    for (int k = 2; k < FL + 3; k++) begin
      step(1'b1);
      if (s_rdy[1]) saw1 = 1'b1;
    end
    chk("wd_never_granted", 32'(saw1), 32'd0);
    chk("wd_idle", 32'(s_valid), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 199) == 0);
      req_valid   = 2'($urandom_range(0, 3));
      req_data[0] = 4'($urandom_range(0, 15));
      req_data[1] = 4'($urandom_range(0, 15));
      ser_ready   = ($urandom_range(0, 3) != 0);
      step(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
